polyphase_interp_fir: RTL

//  Parametrised polyphase interpolating FIR: each accepted input sample yields L output samples.

---
 rtl/polyphase_interp_fir.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/polyphase_interp_fir.sv
// Polyphase interpolating FIR: one input sample yields L output phases.
// A single time-multiplexed MAC walks the P taps of each phase. It also
// provides sample-hold and zero-stuff bypass modes, plus coefficients that
// can be reloaded while the block is idle.
module polyphase_interp_fir #(
  parameter int DW        = 24,
  parameter int CW        = 18,
  parameter int COEF_FRAC = 16,
  parameter int L         = 2,
  parameter int P         = 8,
  parameter int AW        = $clog2(L*P)
) (
  input  logic                   clock_in,
  input  logic                   rstn,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [DW-1:0]          in_data,
  input  logic [1:0]             mode,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DW-1:0]          out_data,
  output logic [$clog2(L)-1:0]   out_phase,
  input  logic                   coef_we,
  input  logic [AW-1:0]          coef_addr,
  input  logic [CW-1:0]          coef_data,
  output logic                   coef_busy
);

  localparam int KW    = (P > 1) ? $clog2(P) : 1;
  localparam int PHW   = $clog2(L);
  localparam int PW    = DW + CW;
  localparam int ACC_W = DW + CW + $clog2(P);
  localparam int NT    = L * P;

  localparam logic [AW:0]             NT_A = (AW+1)'(NT);
  localparam logic signed [ACC_W-1:0] HALF = ACC_W'(longint'(1) << (COEF_FRAC-1));
  localparam logic signed [ACC_W-1:0] MAXV = ACC_W'((longint'(1) << (DW-1)) - 1);
  localparam logic signed [ACC_W-1:0] MINV = ~MAXV;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] MAC  = 2'd1;
  localparam logic [1:0] OUT  = 2'd2;

  logic [1:0]              state;
  logic                    run;
  logic [1:0]              mode_r;
  logic [PHW-1:0]          phase;
  logic [KW-1:0]           k;
  logic signed [ACC_W-1:0] acc;
  logic signed [DW-1:0]    x [P];
  logic signed [CW-1:0]    c [NT];

  logic [AW-1:0]           cidx;
  logic signed [CW-1:0]    cval;
  logic signed [DW-1:0]    xval;
  logic signed [PW-1:0]    prod;
  logic signed [ACC_W-1:0] acc_next;
  logic signed [ACC_W-1:0] rnd;
  logic signed [ACC_W-1:0] shr;
  logic [DW-1:0]           sat_data;
  logic                    filt_in;
  logic                    filt_r;
  logic                    last_phase;

  // Modes 00 and 11 both select the filter path
  assign filt_in    = (mode[1] == mode[0]);
  assign filt_r     = (mode_r[1] == mode_r[0]);
  assign last_phase = (phase == PHW'(L-1));

  assign in_ready  = run && (state == IDLE);
  assign out_valid = (state == OUT);
  assign out_phase = phase;
  assign coef_busy = (state != IDLE);

  // One MAC step, then round half up, then saturate to the output width
  always_comb begin
    cidx     = AW'(int'(phase) * P + int'(k));
    cval     = c[cidx];
    xval     = x[k];
    prod     = cval * xval;
    acc_next = acc + {{(ACC_W-PW){prod[PW-1]}}, prod};
    rnd      = acc_next + HALF;
    shr      = rnd >>> COEF_FRAC;
    if (shr > MAXV)      sat_data = MAXV[DW-1:0];
    else if (shr < MINV) sat_data = MINV[DW-1:0];
    else                 sat_data = shr[DW-1:0];
  end

  // Control FSM, delay line, coefficient store and output register
  always_ff @(posedge clock_in or negedge rstn) begin
    if (!rstn) begin
      state    <= IDLE;
      run      <= 1'b0;
      mode_r   <= '0;
      phase    <= '0;
      k        <= '0;
      acc      <= '0;
      out_data <= '0;
      for (int unsigned i = 0; i < P; i++)  x[i] <= '0;
      for (int unsigned i = 0; i < NT; i++) c[i] <= '0;
    end else begin
      run <= 1'b1;
      case (state)
        IDLE: begin
          // A write in the accept cycle lands before the first MAC step reads it
          if (coef_we && ({1'b0, coef_addr} < NT_A))
            c[coef_addr] <= coef_data;
          if (in_valid && run) begin
            for (int unsigned i = P-1; i > 0; i--) x[i] <= x[i-1];
            x[0]   <= in_data;
            mode_r <= mode;
            phase  <= '0;
            if (filt_in) begin
              state <= MAC;
              k     <= '0;
              acc   <= '0;
            end else begin
              state    <= OUT;
              out_data <= in_data;
            end
          end
        end
        MAC: begin
          acc <= acc_next;
          k   <= k + 1'b1;
          if (k == KW'(P-1)) begin
            out_data <= sat_data;
            state    <= OUT;
          end
        end
        OUT: begin
          if (out_ready) begin
            if (last_phase) begin
              state <= IDLE;
            end else begin
              phase <= phase + 1'b1;
              if (filt_r) begin
                state <= MAC;
                k     <= '0;
                acc   <= '0;
              end else begin
                out_data <= (mode_r == 2'b01) ? x[0] : '0;
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
